// File: rtl/ex_mem_stage_buf_pkg.sv
// Shared definitions for the EX/MEM stage buffer: widths, payload layout
// and the occupancy FSM encoding.
package ex_mem_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 4;

  // Payload width for the default widths: {wb_en, mem_r_en, mem_w_en, alu_res, rm_val, dest}
  localparam int PAYLOAD_W = 3 + 2 * DATA_W_DEF + REG_ADDR_W_DEF;

  // Occupancy FSM; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // Payload width and field offsets for arbitrary widths (dest sits at bit 0).
  function automatic int payload_w(input int dw, input int aw);
    return 3 + 2 * dw + aw;
  endfunction

  function automatic int off_wb(input int dw, input int aw);
    return 2 + 2 * dw + aw;
  endfunction

  function automatic int off_mem_r(input int dw, input int aw);
    return 1 + 2 * dw + aw;
  endfunction

  function automatic int off_mem_w(input int dw, input int aw);
    return 2 * dw + aw;
  endfunction

  function automatic int off_alu(input int dw, input int aw);
    return dw + aw;
  endfunction

  function automatic int off_rm(input int dw, input int aw);
    if (dw < 0) return 0;
    return aw;
  endfunction

endpackage

// File: rtl/ex_mem_stage_buf_if.sv
// EX -> buffer -> MEM handshake bundle.
// Handshake: a transfer happens on an active edge exactly when valid and
// ready are both high; the producer holds payload stable while valid is
// high and not yet accepted; ready never depends combinationally on the
// downstream ready.
interface ex_mem_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  wb_en_in;
  logic                  mem_r_en_in;
  logic                  mem_w_en_in;
  logic [DATA_W-1:0]     alu_res_in;
  logic [DATA_W-1:0]     rm_val_in;
  logic [REG_ADDR_W-1:0] dest_in;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic                  wb_en_out;
  logic                  mem_r_en_out;
  logic                  mem_w_en_out;
  logic [DATA_W-1:0]     alu_res_out;
  logic [DATA_W-1:0]     rm_val_out;
  logic [REG_ADDR_W-1:0] dest_out;
  logic [1:0]            occupancy;

  // Pipeline-control side: drives EX payload, flush and MEM ready.
  modport master (
    output in_valid, wb_en_in, mem_r_en_in, mem_w_en_in,
           alu_res_in, rm_val_in, dest_in, flush, out_ready,
    input  in_ready, out_valid, wb_en_out, mem_r_en_out, mem_w_en_out,
           alu_res_out, rm_val_out, dest_out, occupancy
  );

  // Buffer side.
  modport slave (
    input  in_valid, wb_en_in, mem_r_en_in, mem_w_en_in,
           alu_res_in, rm_val_in, dest_in, flush, out_ready,
    output in_ready, out_valid, wb_en_out, mem_r_en_out, mem_w_en_out,
           alu_res_out, rm_val_out, dest_out, occupancy
  );
endinterface

// File: rtl/stage_entry_reg.sv
// Load-enabled payload register with async active-low clear; the capture
// edge is selected by NEG_EDGE.
module stage_entry_reg #(
  parameter int W        = 71,
  parameter bit NEG_EDGE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (NEG_EDGE) begin : g_neg
    // Capture on the falling edge when loaded.
    always_ff @(negedge clk or negedge rst) begin
      if (!rst)      q <= '0;
      else if (load) q <= d;
    end
  end else begin : g_pos
    // Capture on the rising edge when loaded.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)      q <= '0;
      else if (load) q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_stage_buf.sv
// EX/MEM pipeline buffer: head register H plus skid register S so MEM can
// stall without a combinational ready path back into EX.
module ex_mem_stage_buf
  import ex_mem_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter bit NEG_EDGE   = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  ex_mem_if.slave bus,
  output state_t dbg_state
);

  localparam int PW    = payload_w(DATA_W, REG_ADDR_W);
  localparam int O_WB  = off_wb(DATA_W, REG_ADDR_W);
  localparam int O_MR  = off_mem_r(DATA_W, REG_ADDR_W);
  localparam int O_MW  = off_mem_w(DATA_W, REG_ADDR_W);
  localparam int O_ALU = off_alu(DATA_W, REG_ADDR_W);
  localparam int O_RM  = off_rm(DATA_W, REG_ADDR_W);

  state_t          state_q, state_d;
  logic            push, pop;
  logic            h_load, s_load, h_from_s;
  logic [PW-1:0]   in_payload, h_d, h_q, s_q;

  assign in_payload = {bus.wb_en_in, bus.mem_r_en_in, bus.mem_w_en_in,
                       bus.alu_res_in, bus.rm_val_in, bus.dest_in};

  // Ready comes from the state register only (forced low in reset).
  assign bus.in_ready  = rst & (state_q != ST_TWO);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  if (NEG_EDGE) begin : g_neg
    // State register on the falling edge.
    always_ff @(negedge clk or negedge rst) begin
      if (!rst) state_q <= ST_EMPTY;
      else      state_q <= state_d;
    end
  end else begin : g_pos
    // State register on the rising edge.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_EMPTY;
      else      state_q <= state_d;
    end
  end

  // Next state and register load selection; flush empties and drops input.
  always_comb begin
    state_d  = state_q;
    h_load   = 1'b0;
    s_load   = 1'b0;
    h_from_s = 1'b0;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            h_load  = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            h_load = 1'b1;
          end else if (push) begin
            s_load  = 1'b1;
            state_d = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            h_load   = 1'b1;
            h_from_s = 1'b1;
            state_d  = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign h_d = h_from_s ? s_q : in_payload;

  stage_entry_reg #(.W(PW), .NEG_EDGE(NEG_EDGE)) u_head (
    .clk  (clk),
    .rst  (rst),
    .load (h_load),
    .d    (h_d),
    .q    (h_q)
  );

  stage_entry_reg #(.W(PW), .NEG_EDGE(NEG_EDGE)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (s_load),
    .d    (in_payload),
    .q    (s_q)
  );

  // Data always shows H; control enables are gated so bubbles are inert.
  assign bus.wb_en_out    = h_q[O_WB] & bus.out_valid;
  assign bus.mem_r_en_out = h_q[O_MR] & bus.out_valid;
  assign bus.mem_w_en_out = h_q[O_MW] & bus.out_valid;
  assign bus.alu_res_out  = h_q[O_ALU +: DATA_W];
  assign bus.rm_val_out   = h_q[O_RM +: DATA_W];
  assign bus.dest_out     = h_q[REG_ADDR_W-1:0];
  assign bus.occupancy    = state_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Bench for ex_mem_stage_buf: a falling-edge and a rising-edge instance
// receive identical stimulus and are each checked against a FIFO model.
module tb_ex_mem_stage_buf;
  import ex_mem_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int PW = 3 + 2 * DW + AW;

  logic clk;
  logic rst;
  logic in_valid, wb_en, mr_en, mw_en, out_ready, flush;
  logic [DW-1:0] alu, rm;
  logic [AW-1:0] dest;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] exp_q0[$];
  logic [PW-1:0] exp_q1[$];

  state_t dbg_n, dbg_p;

  ex_mem_if #(.DATA_W(DW), .REG_ADDR_W(AW)) if_n ();
  ex_mem_if #(.DATA_W(DW), .REG_ADDR_W(AW)) if_p ();

  assign if_n.in_valid = in_valid;     assign if_p.in_valid = in_valid;
  assign if_n.wb_en_in = wb_en;        assign if_p.wb_en_in = wb_en;
  assign if_n.mem_r_en_in = mr_en;     assign if_p.mem_r_en_in = mr_en;
  assign if_n.mem_w_en_in = mw_en;     assign if_p.mem_w_en_in = mw_en;
  assign if_n.alu_res_in = alu;        assign if_p.alu_res_in = alu;
  assign if_n.rm_val_in = rm;          assign if_p.rm_val_in = rm;
  assign if_n.dest_in = dest;          assign if_p.dest_in = dest;
  assign if_n.flush = flush;           assign if_p.flush = flush;
  assign if_n.out_ready = out_ready;   assign if_p.out_ready = out_ready;

  ex_mem_stage_buf #(.DATA_W(DW), .REG_ADDR_W(AW), .NEG_EDGE(1'b1)) dut_n (
    .clk(clk), .rst(rst), .bus(if_n.slave), .dbg_state(dbg_n)
  );

  ex_mem_stage_buf #(.DATA_W(DW), .REG_ADDR_W(AW), .NEG_EDGE(1'b0)) dut_p (
    .clk(clk), .rst(rst), .bus(if_p.slave), .dbg_state(dbg_p)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int d, input logic ok,
                       input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut=%0d actual=%h required=%h t=%0t", name, d, act, exp, $time);
    end
  endtask

  // Snapshot of one DUT's outputs.
  task automatic read_dut(input int d, output logic ov, output logic ir,
                          output logic [1:0] occ, output logic [PW-1:0] got);
    if (d == 0) begin
      ov = if_n.out_valid; ir = if_n.in_ready; occ = if_n.occupancy;
      got = {if_n.wb_en_out, if_n.mem_r_en_out, if_n.mem_w_en_out,
             if_n.alu_res_out, if_n.rm_val_out, if_n.dest_out};
    end else begin
      ov = if_p.out_valid; ir = if_p.in_ready; occ = if_p.occupancy;
      got = {if_p.wb_en_out, if_p.mem_r_en_out, if_p.mem_w_en_out,
             if_p.alu_res_out, if_p.rm_val_out, if_p.dest_out};
    end
  endtask

  // Monitor step: compare outputs with the model just before the DUT's
  // active edge, then advance the model with the inputs that edge will see.
  task automatic mon_step(input int d);
    logic ov, ir;
    logic [1:0] occ;
    logic [PW-1:0] got, head, cur;
    int sz;
    read_dut(d, ov, ir, occ, got);
    sz   = (d == 0) ? exp_q0.size() : exp_q1.size();
    head = '0;
    if (sz != 0) head = (d == 0) ? exp_q0[0] : exp_q1[0];
    cur  = {wb_en, mr_en, mw_en, alu, rm, dest};
    if (!rst) begin
      check("rst_in_ready", d, ir == 1'b0, PW'(ir), '0);
      check("rst_out_valid", d, ov == 1'b0, PW'(ov), '0);
      check("rst_payload", d, got == '0, got, '0);
      if (d == 0) exp_q0.delete(); else exp_q1.delete();
      return;
    end
    check("in_ready", d, ir == (sz != 2), PW'(ir), PW'(sz != 2));
    check("occupancy", d, int'(occ) == sz, PW'(occ), PW'(sz));
    check("out_valid", d, ov == (sz != 0), PW'(ov), PW'(sz != 0));
    if (sz != 0) check("head_payload", d, got == head, got, head);
    else         check("bubble_ctl", d, got[PW-1 -: 3] == 3'b000, PW'(got[PW-1 -: 3]), '0);
    if (flush) begin
      if (d == 0) exp_q0.delete(); else exp_q1.delete();
    end else begin
      if (out_ready && sz != 0) begin
        if (d == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
      end
      if (in_valid && sz != 2) begin
        if (d == 0) exp_q0.push_back(cur); else exp_q1.push_back(cur);
      end
    end
  endtask

  // Scoreboard monitors: falling-edge DUT sampled at t=9 mod 10, rising at 4 mod 10.
  always begin
    @(posedge clk);
    #4;
    mon_step(0);
  end

  always begin
    @(negedge clk);
    #4;
    mon_step(1);
  end

  // Driver: inputs change 1 time unit after each rising edge.
  task automatic drive(input logic iv, input logic [2:0] ctl, input logic [DW-1:0] a,
                       input logic [DW-1:0] r, input logic [AW-1:0] dd,
                       input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid = iv;
    {wb_en, mr_en, mw_en} = ctl;
    alu = a; rm = r; dest = dd;
    out_ready = ordy;
    flush = fl;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'b000, '0, '0, '0, ordy, 1'b0);
  endtask

  task automatic check_reset_now();
    logic ov, ir;
    logic [1:0] occ;
    logic [PW-1:0] got;
    for (int d = 0; d < 2; d++) begin
      read_dut(d, ov, ir, occ, got);
      check("async_rst_valid", d, ov == 1'b0, PW'(ov), '0);
      check("async_rst_ready", d, ir == 1'b0, PW'(ir), '0);
      check("async_rst_occ", d, occ == 2'd0, PW'(occ), '0);
      check("async_rst_payload", d, got == '0, got, '0);
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; wb_en = 1'b0; mr_en = 1'b0; mw_en = 1'b0;
    alu = '0; rm = '0; dest = '0; out_ready = 1'b0; flush = 1'b0;
    #2;
    check_reset_now();
    @(posedge clk); #1; rst = 1'b1;
    idle(1'b1, 2);

    // 1: single push with wb_en.
    drive(1'b1, 3'b100, 32'h0000_1234, 32'h0, 4'h5, 1'b1, 1'b0);
    idle(1'b1, 3);

    // 2: stall fills both entries, a third offer is refused, then drain in order.
    drive(1'b1, 3'b000, 32'h0000_000A, 32'h11, 4'h1, 1'b0, 1'b0);
    drive(1'b1, 3'b010, 32'h0000_000B, 32'h22, 4'h2, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 32'h0000_000C, 32'h33, 4'h3, 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 4);

    // 3: back-to-back streaming 1..8.
    for (int i = 1; i <= 8; i++)
      drive(1'b1, 3'b100, DW'(i), DW'(i * 16), AW'(i), 1'b1, 1'b0);
    idle(1'b1, 3);

    // 4: flush while full with a simultaneous store offered.
    drive(1'b1, 3'b100, 32'h0000_0111, 32'h0, 4'h6, 1'b0, 1'b0);
    drive(1'b1, 3'b010, 32'h0000_0222, 32'h0, 4'h7, 1'b0, 1'b0);
    drive(1'b1, 3'b001, 32'h0000_DEAD, 32'hBEEF, 4'h8, 1'b0, 1'b1);
    idle(1'b1, 3);

    // 5: async reset between edges while both entries are held.
    drive(1'b1, 3'b100, 32'h0000_0AAA, 32'h0, 4'h9, 1'b0, 1'b0);
    drive(1'b1, 3'b100, 32'h0000_0BBB, 32'h0, 4'hA, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("pre_rst_occ_n", 0, if_n.occupancy == 2'd2, PW'(if_n.occupancy), PW'(2));
    check("pre_rst_occ_p", 1, if_p.occupancy == 2'd2, PW'(if_p.occupancy), PW'(2));
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_now();
    idle(1'b1, 2);
    @(posedge clk); #1; rst = 1'b1;
    idle(1'b1, 1);
    drive(1'b1, 3'b011, 32'hFFFF_FFFF, 32'h8000_0001, 4'hF, 1'b1, 1'b0);
    idle(1'b1, 4);

    check("final_q_empty_n", 0, exp_q0.size() == 0, PW'(exp_q0.size()), '0);
    check("final_q_empty_p", 1, exp_q1.size() == 0, PW'(exp_q1.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
